freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures an external, slow, asynchronous square wave with the 50 MHz board clock, for example the 1 Hz LED/divider output looped back.
- Reports rising-edge count per fixed gate window (frequency in Hz at default gate) and cycle-accurate period between consecutive rising edges.
- Flags loss of signal. Sits on the receive side of divider/blink outputs for self-test and display.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- GATE_CYCLES, CLK_HZ, gate window length in clk cycles (1 s).
- TIMEOUT_CYCLES, 2*CLK_HZ, cycles without a rising edge before sig_lost.
- FREQ_W, $clog2(GATE_CYCLES/2+1), freq_hz width.
- PER_W, $clog2(TIMEOUT_CYCLES+1), period_cyc width.

Ports:
- clk, input, 1, system clock (CLK_HZ).
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, measurement enable.
- sig_in, input, 1, asynchronous signal under test.
- freq_hz, output, FREQ_W, rising edges counted in last completed gate.
- freq_valid, output, 1, 1-cycle pulse when freq_hz updates.
- period_cyc, output, PER_W, clk cycles between last two rising edges.
- period_valid, output, 1, 1-cycle pulse when period_cyc updates.
- sig_lost, output, 1, no rising edge for TIMEOUT_CYCLES.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: s1/s2/s3, all counters, outputs = 0; armed = 0; state IDLE. Reset mid-gate discards the partial gate.
- Synchronizer: s1<=sig_in, s2<=s1, s3<=s2. Rise event r = s2 & ~s3 (combinational).
  - sig_in sampled high at edge k gives r true in the cycle after edge k+1; counters act on r at edge k+2.
  - sig_in high at reset release yields one r. This is required behaviour.
- FSM IDLE:
  - gate_cnt = edge_cnt = per_cnt = 0; armed = 0; sig_lost = 0.
  - freq_hz and period_cyc hold their last values.
  - en = 1 → MEASURE on the next edge. Gate counting starts that edge.
- FSM MEASURE:
  - en = 0 → IDLE on the next edge. Partial gate discarded, no freq_valid.
  - Each cycle gate_cnt++ and edge_cnt += r.
  - When gate_cnt == GATE_CYCLES-1: freq_hz <= edge_cnt + r (final-cycle rise included), freq_valid = 1 for that one cycle, gate_cnt <= 0, edge_cnt <= 0. The next gate starts immediately with no dead cycle.
  - Width: edge_cnt ≤ GATE_CYCLES/2 because r needs s3 low, so at most one rise per 2 cycles. No overflow possible.
- Period (MEASURE only), on r:
  - If armed: period_cyc <= per_cnt, period_valid = 1 for one cycle.
  - Always: per_cnt <= 1, armed <= 1, sig_lost <= 0.
  - Rises at cycles t0, t1 give period_cyc = t1 − t0.
- Period, no r: per_cnt <= per_cnt+1, saturating at TIMEOUT_CYCLES.
- Timeout: if armed, no r, and per_cnt == TIMEOUT_CYCLES:
  - sig_lost <= 1 (sticky until next r or IDLE), armed <= 0.
  - The next r re-arms only and does not produce period_valid.
- Simultaneous events:
  - r on the gate's last cycle counts in the closing gate, not the new one.
  - freq_valid and period_valid may assert in the same cycle.
  - r and timeout in the same cycle: r wins.
- Outputs are registered. Pulses are exactly one cycle wide.

Test Plan (sim with GATE_CYCLES=1000, TIMEOUT_CYCLES=300 unless noted):
- Reset: rst = 1 for 3 cycles with sig_in = 0 → all outputs 0. freq_valid stays 0 for 1000 cycles with en = 0.
- en = 1, sig_in period 10 cycles (5 high/5 low) → freq_valid every 1000 cycles exactly, freq_hz = 100. period_cyc = 10 from the 2nd rise on, period_valid once per 10 cycles.
- Max rate: sig_in toggled every clk → period_cyc = 2, freq_hz = 500.
- Loss: 5 rises at period 10, then sig_in held 0 → sig_lost = 1 exactly 300 cycles after the last rise's per_cnt reload.
  - Next rise clears sig_lost with no period_valid.
  - The following rise 10 cycles later → period_cyc = 10.
- Gate control: en dropped at gate_cnt = 500 → no freq_valid, freq_hz holds 100.
  - en re-raised → first freq_valid 1000 cycles later.
  - Also: a rise on the gate's final cycle is counted in the closing gate.
- Reset mid-gate: rst at gate_cnt = 700 → outputs 0. With sig_in high at release and en = 1, exactly one rise is counted in the first gate.
- Default params: 1 Hz input with 50% duty → freq_hz = 1, period_cyc = 50000000, sig_lost = 0.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: measures a slow asynchronous square wave against clk.
// Reports rising edges per gate window (freq_hz), the clk-cycle period between
// consecutive rising edges (period_cyc), and a sticky loss-of-signal flag.
//
// Output qualification: freq_valid and period_valid are one-cycle strobes that
// mark the cycle in which freq_hz / period_cyc take a new value. There is no
// ready/back-pressure; a consumer must capture the data in that cycle. Between
// strobes the data outputs hold their last value.
module freq_meter #(
  parameter int CLK_HZ         = 50000000,
  parameter int GATE_CYCLES    = CLK_HZ,
  parameter int TIMEOUT_CYCLES = 2 * CLK_HZ,
  parameter int FREQ_W         = $clog2(GATE_CYCLES / 2 + 1),
  parameter int PER_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sig_in,
  output logic [FREQ_W-1:0] freq_hz,
  output logic              freq_valid,
  output logic [PER_W-1:0]  period_cyc,
  output logic              period_valid,
  output logic              sig_lost,
  output logic              state_dbg
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              s1, s2, s3;
  logic              rise;
  logic              meas_step;
  logic [GATE_W-1:0] gate_cnt;
  logic [FREQ_W-1:0] edge_cnt;
  logic [PER_W-1:0]  per_cnt;
  logic              armed;

  // Rising edge of the synchronised input: s2 high while s3 still low.
  assign rise      = s2 & ~s3;
  assign state_dbg = state_q;

  // Three-flop synchroniser; s3 is the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; meas_step marks cycles whose edge performs a measurement step.
  // A MEASURE cycle with en low is the exit cycle and behaves like IDLE.
  always_comb begin
    state_d   = state_q;
    meas_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = MEASURE;
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          meas_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate window: count rises, publish the count on the window's last cycle
  // (including a rise in that same cycle) and restart with no dead cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
    end else if (!meas_step) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      freq_valid <= 1'b0;
    end else if (gate_cnt == GATE_LAST) begin
      freq_hz    <= edge_cnt + FREQ_W'(rise);
      freq_valid <= 1'b1;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
    end else begin
      gate_cnt   <= gate_cnt + GATE_W'(1);
      edge_cnt   <= edge_cnt + FREQ_W'(rise);
      freq_valid <= 1'b0;
    end
  end

  // Period and loss-of-signal: per_cnt reloads to 1 on each rise and
  // saturates at the timeout; a rise always wins over a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period_cyc   <= '0;
      period_valid <= 1'b0;
      sig_lost     <= 1'b0;
    end else if (!meas_step) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period_valid <= 1'b0;
      sig_lost     <= 1'b0;
    end else if (rise) begin
      if (armed) begin
        period_cyc   <= per_cnt;
        period_valid <= 1'b1;
      end else begin
        period_valid <= 1'b0;
      end
      per_cnt  <= PER_W'(1);
      armed    <= 1'b1;
      sig_lost <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      if (armed && (per_cnt == PER_MAX)) begin
        sig_lost <= 1'b1;
        armed    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter.
// dut uses a short gate (1000) and timeout (300); dut2 uses only CLK_HZ=2000
// so its gate and timeout come from the default parameter derivation.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int GATE  = 1000;
  localparam int TMO   = 300;
  localparam int FW    = $clog2(GATE / 2 + 1);
  localparam int PW    = $clog2(TMO + 1);
  localparam int CLK2  = 2000;
  localparam int FW2   = $clog2(CLK2 / 2 + 1);
  localparam int PW2   = $clog2(2 * CLK2 + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, sig_in, en2, sig_in2;

  logic [FW-1:0]  freq_hz;
  logic           freq_valid;
  logic [PW-1:0]  period_cyc;
  logic           period_valid;
  logic           sig_lost;
  logic           state_dbg;

  logic [FW2-1:0] freq_hz2;
  logic           freq_valid2;
  logic [PW2-1:0] period_cyc2;
  logic           period_valid2;
  logic           sig_lost2;
  logic           state_dbg2;

  freq_meter #(
    .CLK_HZ(50000000), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_hz(freq_hz), .freq_valid(freq_valid),
    .period_cyc(period_cyc), .period_valid(period_valid),
    .sig_lost(sig_lost), .state_dbg(state_dbg)
  );

  freq_meter #(.CLK_HZ(CLK2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .sig_in(sig_in2),
    .freq_hz(freq_hz2), .freq_valid(freq_valid2),
    .period_cyc(period_cyc2), .period_valid(period_valid2),
    .sig_lost(sig_lost2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] fq[$];
  logic [31:0] pq[$];
  logic [31:0] fq2[$];
  logic [31:0] pq2[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fv_last = -1;
  int fv2_last = -1;
  int fv_cnt = 0;
  int pv_cnt = 0;
  bit both_seen = 1'b0;
  int gen_per = 10;
  int gen_high = 5;
  int ph = 0;
  int ph2 = 0;

  // One clock: advance, then compare any strobed output against the queues.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (freq_valid === 1'b1) begin
      fv_last = cyc;
      fv_cnt++;
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL freq_unexpected cyc=%0d got=%0d want=none", cyc, freq_hz);
      end else begin
        e = fq.pop_front();
        if (32'(freq_hz) !== e) begin
          bad++;
          $display("FAIL freq_value cyc=%0d got=%0d want=%0d", cyc, freq_hz, e);
        end
      end
    end
    if (period_valid === 1'b1) begin
      pv_cnt++;
      total++;
      if (pq.size() == 0) begin
        bad++;
        $display("FAIL period_unexpected cyc=%0d got=%0d want=none", cyc, period_cyc);
      end else begin
        e = pq.pop_front();
        if (32'(period_cyc) !== e) begin
          bad++;
          $display("FAIL period_value cyc=%0d got=%0d want=%0d", cyc, period_cyc, e);
        end
      end
    end
    if (freq_valid === 1'b1 && period_valid === 1'b1) both_seen = 1'b1;
    if (freq_valid2 === 1'b1) begin
      fv2_last = cyc;
      total++;
      if (fq2.size() == 0) begin
        bad++;
        $display("FAIL freq2_unexpected cyc=%0d got=%0d want=none", cyc, freq_hz2);
      end else begin
        e = fq2.pop_front();
        if (32'(freq_hz2) !== e) begin
          bad++;
          $display("FAIL freq2_value cyc=%0d got=%0d want=%0d", cyc, freq_hz2, e);
        end
      end
    end
    if (period_valid2 === 1'b1) begin
      total++;
      if (pq2.size() == 0) begin
        bad++;
        $display("FAIL period2_unexpected cyc=%0d got=%0d want=none", cyc, period_cyc2);
      end else begin
        e = pq2.pop_front();
        if (32'(period_cyc2) !== e) begin
          bad++;
          $display("FAIL period2_value cyc=%0d got=%0d want=%0d", cyc, period_cyc2, e);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drive_wave(input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = (ph < gen_high);
      ph = (ph + 1 == gen_per) ? 0 : ph + 1;
      tick();
    end
  endtask

  task automatic pulse(input int t);
    wait_until(t);
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] v, input bit to_period);
    for (int i = 0; i < n; i++) begin
      if (to_period) pq.push_back(v);
      else fq.push_back(v);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; en2 = 1'b0; sig_in2 = 1'b0;
    repeat (3) tick();
    total++;
    if (freq_hz !== '0 || freq_valid !== 1'b0) begin
      bad++; $display("FAIL reset_freq got=%0d/%0b want=0/0", freq_hz, freq_valid);
    end
    total++;
    if (period_cyc !== '0 || period_valid !== 1'b0) begin
      bad++; $display("FAIL reset_period got=%0d/%0b want=0/0", period_cyc, period_valid);
    end
    total++;
    if (sig_lost !== 1'b0 || state_dbg !== 1'b0) begin
      bad++; $display("FAIL reset_lost_state got=%0b/%0b want=0/0", sig_lost, state_dbg);
    end
    total++;
    if (freq_hz2 !== '0 || period_cyc2 !== '0 || sig_lost2 !== 1'b0 || state_dbg2 !== 1'b0) begin
      bad++; $display("FAIL reset_dut2 got=%0d/%0d/%0b/%0b want=0/0/0/0",
                      freq_hz2, period_cyc2, sig_lost2, state_dbg2);
    end
    rst = 1'b0;
    gen_per = 10; gen_high = 5; ph = 0;
    drive_wave(1000);
    total++;
    if (fv_cnt != 0 || pv_cnt != 0 || sig_lost !== 1'b0) begin
      bad++; $display("FAIL idle_quiet got fv=%0d pv=%0d lost=%0b want=0/0/0", fv_cnt, pv_cnt, sig_lost);
    end
    sig_in = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_basic();
    int n;
    gen_per = 10; gen_high = 5; ph = 0;
    n = cyc;
    en = 1'b1;
    push_n(2, 100, 1'b0);
    push_n(200, 10, 1'b1);
    drive_wave(1003);
    total++;
    if (fv_last != n + 1001) begin
      bad++; $display("FAIL basic_first_gate got=%0d want=%0d", fv_last, n + 1001);
    end
    drive_wave(1002);
    total++;
    if (fv_last != n + 2001) begin
      bad++; $display("FAIL basic_second_gate got=%0d want=%0d", fv_last, n + 2001);
    end
    total++;
    if (freq_hz !== 9'd100 || period_cyc !== 9'd10 || sig_lost !== 1'b0 || state_dbg !== 1'b1) begin
      bad++; $display("FAIL basic_outputs got=%0d/%0d/%0b/%0b want=100/10/0/1",
                      freq_hz, period_cyc, sig_lost, state_dbg);
    end
    en = 1'b0; sig_in = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL basic_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_max_rate();
    int n;
    gen_per = 2; gen_high = 1; ph = 0;
    n = cyc;
    en = 1'b1;
    push_n(2, 500, 1'b0);
    push_n(999, 2, 1'b1);
    drive_wave(2000);
    sig_in = 1'b0;
    repeat (3) tick();
    total++;
    if (fv_last != n + 2001 || freq_hz !== 9'd500 || period_cyc !== 9'd2) begin
      bad++; $display("FAIL maxrate got=%0d/%0d/%0d want=%0d/500/2", fv_last, freq_hz, period_cyc, n + 2001);
    end
    en = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL maxrate_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_loss();
    int n;
    gen_per = 10; gen_high = 5; ph = 0;
    n = cyc;
    en = 1'b1;
    push_n(1, 7, 1'b0);
    push_n(4, 10, 1'b1);
    drive_wave(45);
    sig_in = 1'b0;
    while (sig_lost !== 1'b1 && cyc < n + 500) tick();
    total++;
    if (cyc != n + 343 || sig_lost !== 1'b1) begin
      bad++; $display("FAIL loss_timing got=%0d/%0b want=%0d/1", cyc, sig_lost, n + 343);
    end
    push_n(1, 10, 1'b1);
    wait_until(n + 350);
    ph = 0;
    drive_wave(15);
    sig_in = 1'b0;
    tick();
    total++;
    if (sig_lost !== 1'b0 || period_cyc !== 9'd10) begin
      bad++; $display("FAIL loss_recover got=%0b/%0d want=0/10", sig_lost, period_cyc);
    end
    wait_until(n + 1003);
    total++;
    if (fv_last != n + 1001 || sig_lost !== 1'b1) begin
      bad++; $display("FAIL loss_gate got=%0d/%0b want=%0d/1", fv_last, sig_lost, n + 1001);
    end
    en = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL loss_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_gate_ctl();
    int n, m;
    gen_per = 10; gen_high = 5; ph = 0;
    n = cyc;
    en = 1'b1;
    push_n(1, 100, 1'b0);
    push_n(149, 10, 1'b1);
    drive_wave(1501);
    en = 1'b0;
    drive_wave(1000);
    total++;
    if (fv_last != n + 1001 || freq_hz !== 9'd100 || fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL gate_drop got=%0d/%0d/%0d/%0d want=%0d/100/0/0",
                      fv_last, freq_hz, fq.size(), pq.size(), n + 1001);
    end
    m = cyc;
    en = 1'b1;
    push_n(1, 100, 1'b0);
    push_n(101, 10, 1'b1);
    drive_wave(1014);
    total++;
    if (fv_last != m + 1001 || freq_hz !== 9'd100) begin
      bad++; $display("FAIL gate_rearm got=%0d/%0d want=%0d/100", fv_last, freq_hz, m + 1001);
    end
    en = 1'b0; sig_in = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL gate_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_gate_edge();
    int n;
    n = cyc;
    en = 1'b1;
    both_seen = 1'b0;
    push_n(1, 2, 1'b0);
    push_n(1, 1, 1'b0);
    push_n(1, 10, 1'b1);
    push_n(1, 2, 1'b1);
    pulse(n + 988);
    pulse(n + 998);
    pulse(n + 1000);
    wait_until(n + 2003);
    total++;
    if (fv_last != n + 2001 || both_seen !== 1'b1) begin
      bad++; $display("FAIL edge_gate got=%0d/%0b want=%0d/1", fv_last, both_seen, n + 2001);
    end
    total++;
    if (sig_lost !== 1'b1 || period_cyc !== 9'd2) begin
      bad++; $display("FAIL edge_sticky got=%0b/%0d want=1/2", sig_lost, period_cyc);
    end
    en = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL edge_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = cyc;
    en = 1'b1;
    wait_until(n + 701);
    rst = 1'b1;
    sig_in = 1'b1;
    repeat (3) tick();
    total++;
    if (freq_hz !== '0 || period_cyc !== '0 || sig_lost !== 1'b0 ||
        freq_valid !== 1'b0 || state_dbg !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%0d/%0d/%0b/%0b/%0b want=0/0/0/0/0",
                      freq_hz, period_cyc, sig_lost, freq_valid, state_dbg);
    end
    rst = 1'b0;
    push_n(1, 1, 1'b0);
    wait_until(n + 1707);
    total++;
    if (fv_last != n + 1705) begin
      bad++; $display("FAIL midreset_gate got=%0d want=%0d", fv_last, n + 1705);
    end
    en = 1'b0; sig_in = 1'b0;
    repeat (5) tick();
    total++;
    if (fq.size() != 0 || pq.size() != 0) begin
      bad++; $display("FAIL midreset_pending got=%0d/%0d want=0/0", fq.size(), pq.size());
    end
  endtask

  task automatic test_default();
    int n;
    ph2 = 0;
    n = cyc;
    en2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fq2.push_back(32'd1);
      pq2.push_back(32'd2000);
    end
    for (int i = 0; i < 6005; i++) begin
      sig_in2 = (ph2 < 1000);
      ph2 = (ph2 + 1 == 2000) ? 0 : ph2 + 1;
      tick();
    end
    total++;
    if (freq_hz2 !== 10'd1 || period_cyc2 !== 12'd2000 || sig_lost2 !== 1'b0) begin
      bad++; $display("FAIL default_outputs got=%0d/%0d/%0b want=1/2000/0",
                      freq_hz2, period_cyc2, sig_lost2);
    end
    total++;
    if (fv2_last != n + 6001 || fq2.size() != 0 || pq2.size() != 0) begin
      bad++; $display("FAIL default_gate got=%0d/%0d/%0d want=%0d/0/0",
                      fv2_last, fq2.size(), pq2.size(), n + 6001);
    end
    en2 = 1'b0; sig_in2 = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_max_rate();
    test_loss();
    test_gate_ctl();
    test_gate_edge();
    test_reset_mid();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
